// File: rtl/medidor_pwm_if.sv
// Signal bundle between the PWM meter and its environment: PWM input plus measurement results.
interface medidor_pwm_if #(
    parameter int N = 50000
);
    logic                 pwm_in;
    logic [$clog2(N)-1:0] largura;
    logic [31:0]          periodo;
    logic                 pronto;
    logic                 fora_faixa;
    logic                 sinal_perdido;

    modport master (
        output pwm_in,
        input  largura, periodo, pronto, fora_faixa, sinal_perdido
    );

    modport slave (
        input  pwm_in,
        output largura, periodo, pronto, fora_faixa, sinal_perdido
    );
endinterface

// File: rtl/medidor_pwm.sv
// PWM meter: recovers the servo width command (high time minus offset), the period,
// and flags loss of signal.
//
// state         | meaning
// ESPERA_BAIXO  | discard any partial pulse, wait for the synchronized input to be low
// ESPERA_SUBIDA | idle low, wait for a rising edge (total runs for the timeout)
// MEDE_ALTO     | counting high time of the current pulse
// MEDE_BAIXO    | counting low time until the next rising edge closes the period
module medidor_pwm #(
    parameter int conf_periodo = 1000000,
    parameter int defasagem    = conf_periodo / 20,
    parameter int N            = 50000
) (
    input  logic          clock,
    input  logic          reset,
    medidor_pwm_if.slave  bus
);
    localparam int LW = $clog2(N);
    localparam logic [31:0]   C_PERIODO = 32'(conf_periodo);
    localparam logic [31:0]   C_TIMEOUT = 32'(2 * conf_periodo);
    localparam logic [31:0]   C_DEF     = 32'(defasagem);
    localparam logic [31:0]   C_MAX     = 32'(N - 1);
    localparam logic [LW-1:0] C_MAX_L   = LW'(N - 1);

    typedef enum logic [1:0] {
        ESPERA_BAIXO,
        ESPERA_SUBIDA,
        MEDE_ALTO,
        MEDE_BAIXO
    } estado_t;

    estado_t       r_estado, w_prox;
    logic          r_s1, r_s2, r_s3;
    logic [1:0]    r_aquec;
    logic [31:0]   r_alto, r_total, r_periodo;
    logic [LW-1:0] r_largura;
    logic          r_pronto, r_fora, r_perdido;

    logic          w_subida, w_descida, w_sinc_ok;
    logic          w_reinicia, w_conta, w_conta_alto, w_fecha, w_perde, w_zera_total, w_grava_periodo;
    logic [31:0]   w_diff;
    logic [LW-1:0] w_largura;
    logic          w_fora;

    assign w_subida  = r_s2 & ~r_s3;
    assign w_descida = ~r_s2 & r_s3;
    // Synchronizer resets to 0, so a line already high at reset release must not look like a fresh edge.
    assign w_sinc_ok = (r_aquec == 2'd2);

    assign w_diff = r_alto - C_DEF;
    always_comb begin
        w_largura = w_diff[LW-1:0];
        w_fora    = 1'b0;
        if (r_alto < C_DEF) begin
            w_largura = '0;
            w_fora    = 1'b1;
        end else if (w_diff > C_MAX) begin
            w_largura = C_MAX_L;
            w_fora    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= ESPERA_BAIXO;
        else       r_estado <= w_prox;
    end

    always_comb begin
        w_prox           = r_estado;
        w_reinicia       = 1'b0;
        w_conta          = 1'b0;
        w_conta_alto     = 1'b0;
        w_fecha          = 1'b0;
        w_perde          = 1'b0;
        w_zera_total     = 1'b0;
        w_grava_periodo  = 1'b0;
        case (r_estado)
            ESPERA_BAIXO: begin
                w_zera_total = 1'b1;
                if (w_sinc_ok && !r_s2) w_prox = ESPERA_SUBIDA;
            end
            ESPERA_SUBIDA: begin
                if (w_subida) begin
                    w_reinicia = 1'b1;
                    w_prox     = MEDE_ALTO;
                end else if (r_total >= C_TIMEOUT) begin
                    w_perde      = 1'b1;
                    w_zera_total = 1'b1;
                end else begin
                    w_conta = 1'b1;
                end
            end
            MEDE_ALTO: begin
                if (w_descida) begin
                    w_fecha = 1'b1;
                    w_conta = 1'b1;
                    w_prox  = MEDE_BAIXO;
                end else if (r_alto >= C_PERIODO) begin
                    w_perde = 1'b1;
                    w_prox  = ESPERA_BAIXO;
                end else begin
                    w_conta      = 1'b1;
                    w_conta_alto = 1'b1;
                end
            end
            MEDE_BAIXO: begin
                if (w_subida) begin
                    w_grava_periodo = 1'b1;
                    w_reinicia      = 1'b1;
                    w_prox          = MEDE_ALTO;
                end else if (r_total >= C_TIMEOUT) begin
                    w_perde      = 1'b1;
                    w_zera_total = 1'b1;
                    w_prox       = ESPERA_SUBIDA;
                end else begin
                    w_conta = 1'b1;
                end
            end
            default: w_prox = ESPERA_BAIXO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_aquec   <= '0;
            r_alto    <= '0;
            r_total   <= '0;
            r_periodo <= '0;
            r_largura <= '0;
            r_pronto  <= 1'b0;
            r_fora    <= 1'b0;
            r_perdido <= 1'b0;
        end else begin
            r_s1     <= bus.pwm_in;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_pronto <= w_fecha;
            if (!w_sinc_ok) r_aquec <= r_aquec + 2'd1;
            if (w_reinicia) begin
                r_alto  <= 32'd1;
                r_total <= 32'd1;
            end else begin
                if (w_conta_alto && r_alto != '1) r_alto <= r_alto + 32'd1;
                if (w_zera_total)                  r_total <= '0;
                else if (w_conta && r_total != '1) r_total <= r_total + 32'd1;
            end
            if (w_grava_periodo) r_periodo <= r_total;
            if (w_fecha) begin
                r_largura <= w_largura;
                r_fora    <= w_fora;
            end
            if (w_fecha)      r_perdido <= 1'b0;
            else if (w_perde) r_perdido <= 1'b1;
        end
    end

    assign bus.largura       = r_largura;
    assign bus.periodo       = r_periodo;
    assign bus.pronto        = r_pronto;
    assign bus.fora_faixa    = r_fora;
    assign bus.sinal_perdido = r_perdido;
endmodule
